// File: rtl/div_seq_pkg.sv
// rtl/div_seq_pkg.sv - shared types and constants for the divide sequencer
package div_seq_pkg;

  localparam int DIV_DATA_W = 32;

  typedef enum logic [1:0] {
    DIV_FREE   = 2'b00,
    DIV_BYZERO = 2'b01,
    DIV_ON     = 2'b10,
    DIV_END    = 2'b11
  } div_state_e;

endpackage

// File: rtl/div_step.sv
// rtl/div_step.sv - one restoring-divide step: trial subtract and quotient bit
module div_step #(
  parameter int DATA_W = 32
) (
  input  logic [DATA_W:0]   partial,
  input  logic [DATA_W-1:0] divisor,
  output logic [DATA_W-1:0] next_partial,
  output logic              q_bit
);

  // When the subtraction succeeds the difference is below the divisor, so W bits suffice.
  assign q_bit        = (partial >= {1'b0, divisor});
  assign next_partial = q_bit ? (partial[DATA_W-1:0] - divisor) : partial[DATA_W-1:0];

endmodule

// File: rtl/div_seq.sv
// rtl/div_seq.sv - multi-cycle radix-2 restoring divider with pipeline stall request
module div_seq
  import div_seq_pkg::*;
#(
  parameter int DATA_W = DIV_DATA_W
) (
  input  logic                clk,
  input  logic                rst,
  input  logic                signed_div_i,
  input  logic [DATA_W-1:0]   opdata1_i,
  input  logic [DATA_W-1:0]   opdata2_i,
  input  logic                start_i,
  input  logic                annul_i,
  output logic [2*DATA_W-1:0] result_o,
  output logic                ready_o,
  output logic                stallreq_o
);

  localparam int CNT_W = $clog2(DATA_W + 1);
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(DATA_W);

  div_state_e        state;
  logic [CNT_W-1:0]  cnt;
  logic [2*DATA_W:0] dividend;
  logic [DATA_W-1:0] divisor;
  logic              neg_quot;
  logic              neg_rem;
  logic [DATA_W-1:0] mag_a;
  logic [DATA_W-1:0] mag_b;
  logic [DATA_W-1:0] next_partial;
  logic              q_bit;
  logic [DATA_W-1:0] quot;
  logic [DATA_W-1:0] rem;

  assign mag_a = (signed_div_i && opdata1_i[DATA_W-1]) ? -opdata1_i : opdata1_i;
  assign mag_b = (signed_div_i && opdata2_i[DATA_W-1]) ? -opdata2_i : opdata2_i;
  assign quot  = dividend[DATA_W-1:0];
  assign rem   = dividend[2*DATA_W:DATA_W+1];

  div_step #(.DATA_W(DATA_W)) u_step (
    .partial      (dividend[2*DATA_W:DATA_W]),
    .divisor      (divisor),
    .next_partial (next_partial),
    .q_bit        (q_bit)
  );

  assign stallreq_o = start_i & ~ready_o & ~annul_i;

  always_ff @(posedge clk) begin
    if (rst) begin
      state    <= DIV_FREE;
      cnt      <= '0;
      dividend <= '0;
      divisor  <= '0;
      neg_quot <= 1'b0;
      neg_rem  <= 1'b0;
      result_o <= '0;
      ready_o  <= 1'b0;
    end else begin
      case (state)
        DIV_FREE: begin
          if (start_i && !annul_i) begin
            if (opdata2_i == '0) begin
              state <= DIV_BYZERO;
            end else begin
              state    <= DIV_ON;
              cnt      <= '0;
              dividend <= {{DATA_W{1'b0}}, mag_a, 1'b0};
              divisor  <= mag_b;
              neg_quot <= signed_div_i & (opdata1_i[DATA_W-1] ^ opdata2_i[DATA_W-1]);
              neg_rem  <= signed_div_i & opdata1_i[DATA_W-1];
            end
          end
        end
        DIV_BYZERO: begin
          dividend <= '0;
          state    <= DIV_END;
        end
        DIV_ON: begin
          if (annul_i) begin
            state <= DIV_FREE;
          end else if (cnt != CNT_LAST) begin
            dividend <= {next_partial, dividend[DATA_W-1:0], q_bit};
            cnt      <= cnt + 1'b1;
          end else begin
            // Magnitudes are done; restore signs modulo 2^DATA_W.
            dividend[DATA_W-1:0]          <= neg_quot ? -quot : quot;
            dividend[2*DATA_W:DATA_W+1]   <= neg_rem ? -rem : rem;
            cnt                           <= '0;
            state                         <= DIV_END;
          end
        end
        DIV_END: begin
          if (!start_i || annul_i) begin
            state   <= DIV_FREE;
            ready_o <= 1'b0;
          end else begin
            result_o <= {rem, quot};
            ready_o  <= 1'b1;
          end
        end
        default: state <= DIV_FREE;
      endcase
    end
  end

endmodule
